// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   Bundle of the signals that pass through the execute stage of the RV32
//   pipeline. It carries the decode-to-execute inputs, the writeback-stage
//   forwarding source, the combinational branch outputs and the registered
//   execute-to-memory outputs.
//
//   modport master : drives the E-stage and W-stage inputs and observes the
//                    branch decision and the *M outputs (decode side / bench)
//   modport slave  : the execute stage itself
// -----------------------------------------------------------------------------
interface execute_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Decode-to-execute control
    logic              RegWriteE;
    logic              ALUSrcE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              BranchE;
    logic [2:0]        ALUControlE;
    // Decode-to-execute data
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmExtE;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [REG_W-1:0]  RS1E;
    logic [REG_W-1:0]  RS2E;
    logic [REG_W-1:0]  RDE;
    // Writeback-stage forwarding source
    logic              RegWriteW;
    logic [REG_W-1:0]  RDW;
    logic [DATA_W-1:0] ResultW;
    // Branch decision (combinational)
    logic              PCSrcE;
    logic [DATA_W-1:0] PCTargetE;
    // Execute-to-memory pipeline register
    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic [DATA_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [REG_W-1:0]  RDM;
    logic [DATA_W-1:0] PCPlus4M;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RDE,
        output RegWriteW, RDW, ResultW,
        input  PCSrcE, PCTargetE,
        input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RDE,
        input  RegWriteW, RDW, ResultW,
        output PCSrcE, PCTargetE,
        output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage of the 5-stage RV32 pipeline. Selects the ALU operands
//   (optionally forwarded from the M and W stages), computes the ALU result,
//   resolves BEQ (PCSrcE / PCTargetE, same cycle) and registers the
//   execute-to-memory state with one cycle of latency and no enable.
//
//   Ports:
//     clk  - pipeline clock, rising edge
//     rst  - asynchronous reset, active-low; clears every *M output
//     bus  - execute_stage_if.slave: E-stage inputs, W-stage forwarding
//            source, PCSrcE/PCTargetE and the registered *M outputs
//
//   Build option:
//     EXEC_FORWARDING_EN - when defined, RS1E/RS2E operands are bypassed from
//                          the M stage (priority) or the W stage; otherwise
//                          RD1E/RD2E are used as-is.
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  bus
);

    // Operand and ALU signals
    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;
    logic [DATA_W-1:0] src_b_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              zero_s;

    // Execute-to-memory pipeline register
    logic              reg_write_r;
    logic              mem_write_r;
    logic              result_src_r;
    logic [DATA_W-1:0] alu_result_r;
    logic [DATA_W-1:0] write_data_r;
    logic [REG_W-1:0]  rd_r;
    logic [DATA_W-1:0] pc_plus4_r;

`ifdef EXEC_FORWARDING_EN
    // Operand bypass: the instruction one ahead (M) is newer than W, so it wins.
    // A load in M forwards its address, not its data; the hazard unit stalls
    // that case before it reaches here.
    always_comb begin
        fwd_a_s = bus.RD1E;
        fwd_b_s = bus.RD2E;
        if (reg_write_r && (rd_r != {REG_W{1'b0}}) && (rd_r == bus.RS1E)) begin
            fwd_a_s = alu_result_r;
        end else if (bus.RegWriteW && (bus.RDW != {REG_W{1'b0}}) && (bus.RDW == bus.RS1E)) begin
            fwd_a_s = bus.ResultW;
        end else begin
            fwd_a_s = bus.RD1E;
        end
        if (reg_write_r && (rd_r != {REG_W{1'b0}}) && (rd_r == bus.RS2E)) begin
            fwd_b_s = alu_result_r;
        end else if (bus.RegWriteW && (bus.RDW != {REG_W{1'b0}}) && (bus.RDW == bus.RS2E)) begin
            fwd_b_s = bus.ResultW;
        end else begin
            fwd_b_s = bus.RD2E;
        end
    end
`else
    // Without bypassing the register-file values are used directly.
    always_comb begin
        fwd_a_s = bus.RD1E;
        fwd_b_s = bus.RD2E;
    end

    // Forwarding-source inputs remain on the interface but carry no meaning here.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{bus.RS1E, bus.RS2E, bus.RegWriteW, bus.RDW, bus.ResultW};
`endif

    // Second ALU operand: immediate or (possibly forwarded) register.
    always_comb begin
        src_b_s = fwd_b_s;
        if (bus.ALUSrcE) begin
            src_b_s = bus.ImmExtE;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    // ALU: arithmetic wraps modulo 2^DATA_W; shifts use only SrcB[4:0].
    always_comb begin
        alu_result_s = {DATA_W{1'b0}};
        case (bus.ALUControlE)
            3'b000: alu_result_s = fwd_a_s + src_b_s;
            3'b001: alu_result_s = fwd_a_s - src_b_s;
            3'b010: alu_result_s = fwd_a_s & src_b_s;
            3'b011: alu_result_s = fwd_a_s | src_b_s;
            3'b100: alu_result_s = fwd_a_s ^ src_b_s;
            3'b101: begin
                if ($signed(fwd_a_s) < $signed(src_b_s)) begin
                    alu_result_s = {{(DATA_W-1){1'b0}}, 1'b1};
                end else begin
                    alu_result_s = {DATA_W{1'b0}};
                end
            end
            3'b110: alu_result_s = fwd_a_s << src_b_s[4:0];
            3'b111: alu_result_s = fwd_a_s >> src_b_s[4:0];
            default: alu_result_s = {DATA_W{1'b0}};
        endcase
    end

    assign zero_s        = (alu_result_s == {DATA_W{1'b0}});
    assign bus.PCSrcE    = bus.BranchE & zero_s;
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    // Execute-to-memory pipeline register; reset acts immediately, mid-cycle too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            result_src_r <= 1'b0;
            alu_result_r <= {DATA_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
            rd_r         <= {REG_W{1'b0}};
            pc_plus4_r   <= {DATA_W{1'b0}};
        end else begin
            reg_write_r  <= bus.RegWriteE;
            mem_write_r  <= bus.MemWriteE;
            result_src_r <= bus.ResultSrcE;
            alu_result_r <= alu_result_s;
            write_data_r <= fwd_b_s;
            rd_r         <= bus.RDE;
            pc_plus4_r   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = reg_write_r;
    assign bus.MemWriteM  = mem_write_r;
    assign bus.ResultSrcM = result_src_r;
    assign bus.ALUResultM = alu_result_r;
    assign bus.WriteDataM = write_data_r;
    assign bus.RDM        = rd_r;
    assign bus.PCPlus4M   = pc_plus4_r;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed and randomized checks of execute_stage against a behavioural
//   model. The model keeps its own copy of the M-stage state (what the last
//   instruction produced) and derives every expectation from the ISA rules.
//   Expectations follow EXEC_FORWARDING_EN as compiled.
// -----------------------------------------------------------------------------
module tb_execute_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    execute_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    execute_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model copy of the M-stage state
    logic        m_rw, m_mw, m_rs;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] regval);
`ifdef EXEC_FORWARDING_EN
        if (m_rw && m_rd != 5'd0 && m_rd == rs) return m_alu;
        if (bus.RegWriteW && bus.RDW != 5'd0 && bus.RDW == rs) return bus.ResultW;
        return regval;
`else
        return regval;
`endif
    endfunction

    task automatic model_clear();
        m_rw = 1'b0; m_mw = 1'b0; m_rs = 1'b0;
        m_alu = 32'd0; m_wd = 32'd0; m_pc4 = 32'd0; m_rd = 5'd0;
    endtask

    task automatic check_m(input string tag);
        check({tag, ".RegWriteM"},  {31'd0, bus.RegWriteM},  {31'd0, m_rw});
        check({tag, ".MemWriteM"},  {31'd0, bus.MemWriteM},  {31'd0, m_mw});
        check({tag, ".ResultSrcM"}, {31'd0, bus.ResultSrcM}, {31'd0, m_rs});
        check({tag, ".ALUResultM"}, bus.ALUResultM, m_alu);
        check({tag, ".WriteDataM"}, bus.WriteDataM, m_wd);
        check({tag, ".RDM"},        {27'd0, bus.RDM},        {27'd0, m_rd});
        check({tag, ".PCPlus4M"},   bus.PCPlus4M, m_pc4);
    endtask

    // Check the combinational branch outputs, clock one edge, check the M stage.
    task automatic step(input string tag);
        logic [31:0] a, b, res;
        #1;
        a   = fwd_ref(bus.RS1E, bus.RD1E);
        b   = fwd_ref(bus.RS2E, bus.RD2E);
        res = alu_ref(bus.ALUControlE, a, bus.ALUSrcE ? bus.ImmExtE : b);
        check({tag, ".PCSrcE"}, {31'd0, bus.PCSrcE}, {31'd0, (bus.BranchE && res == 32'd0)});
        check({tag, ".PCTargetE"}, bus.PCTargetE, bus.PCE + bus.ImmExtE);
        @(posedge clk);
        m_rw = bus.RegWriteE; m_mw = bus.MemWriteE; m_rs = bus.ResultSrcE;
        m_alu = res; m_wd = b; m_rd = bus.RDE; m_pc4 = bus.PCPlus4E;
        #1;
        check_m(tag);
    endtask

    task automatic clear_inputs();
        bus.RegWriteE = 1'b0; bus.ALUSrcE = 1'b0; bus.MemWriteE = 1'b0;
        bus.ResultSrcE = 1'b0; bus.BranchE = 1'b0; bus.ALUControlE = 3'd0;
        bus.RD1E = 32'd0; bus.RD2E = 32'd0; bus.ImmExtE = 32'd0;
        bus.PCE = 32'd0; bus.PCPlus4E = 32'd0;
        bus.RS1E = 5'd0; bus.RS2E = 5'd0; bus.RDE = 5'd0;
        bus.RegWriteW = 1'b0; bus.RDW = 5'd0; bus.ResultW = 32'd0;
    endtask

    // ADD-immediate with zero immediate: ALUResultM shows the forwarded SrcA.
    task automatic read_srca(input logic [4:0] rs1, input logic [31:0] rd1, input logic [4:0] rd);
        clear_inputs();
        bus.RS1E = rs1; bus.RD1E = rd1; bus.ALUSrcE = 1'b1; bus.RDE = rd; bus.RegWriteE = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        model_clear();

        // Reset state
        @(posedge clk); #1;
        check_m("reset");
        #3 rst = 1'b1;
        @(posedge clk); #1;

        // 1: ADD immediate
        clear_inputs();
        bus.RD1E = 32'd5; bus.ImmExtE = 32'd7; bus.ALUSrcE = 1'b1; bus.RDE = 5'd3;
        bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h104;
        step("add_imm");
        check("add_imm.const", bus.ALUResultM, 32'd12);

        // 2: BEQ taken / not taken
        clear_inputs();
        bus.RD1E = 32'h10; bus.RD2E = 32'h10; bus.ALUControlE = 3'b001; bus.BranchE = 1'b1;
        bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
        #1;
        check("beq.taken", {31'd0, bus.PCSrcE}, 32'd1);
        check("beq.target", bus.PCTargetE, 32'h0000_00F8);
        step("beq_taken");
        bus.RD2E = 32'h11;
        #1;
        check("beq.not_taken", {31'd0, bus.PCSrcE}, 32'd0);
        step("beq_not_taken");

        // 3: arithmetic edges
        clear_inputs();
        bus.RD1E = 32'hFFFF_FFFF; bus.ImmExtE = 32'd1; bus.ALUSrcE = 1'b1;
        step("add_wrap");
        check("add_wrap.const", bus.ALUResultM, 32'd0);
        bus.ALUControlE = 3'b101;
        step("slt_signed");
        check("slt_signed.const", bus.ALUResultM, 32'd1);
        bus.RD1E = 32'h8000_0000; bus.ImmExtE = 32'd31; bus.ALUControlE = 3'b111;
        step("srl31");
        check("srl31.const", bus.ALUResultM, 32'd1);
        bus.RD1E = 32'd3; bus.ImmExtE = 32'h21; bus.ALUControlE = 3'b110;
        step("sll_mask");
        check("sll_mask.const", bus.ALUResultM, 32'd6);

        // 4: reset between edges
        clear_inputs();
        bus.RD1E = 32'h1234; bus.ALUSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.RDE = 5'd9;
        bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1; bus.PCPlus4E = 32'h44; bus.RD2E = 32'h55;
        step("pre_reset");
        #3 rst = 1'b0;
        model_clear();
        #1 check_m("reset_async");
        @(posedge clk); #1;
        check_m("reset_hold");
        #3 rst = 1'b1;
        step("after_reset");

        // 5: operand forwarding
        read_srca(5'd0, 32'd9, 5'd5);
        step("fw_producer");
        read_srca(5'd5, 32'd0, 5'd6);
        step("fw_m");
`ifdef EXEC_FORWARDING_EN
        check("fw_m.const", bus.ALUResultM, 32'd9);
`else
        check("fw_m.const", bus.ALUResultM, 32'd0);
`endif
        read_srca(5'd0, 32'd9, 5'd5);
        step("fw_producer2");
        read_srca(5'd5, 32'd0, 5'd6);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd5; bus.ResultW = 32'd4;
        step("fw_m_over_w");
`ifdef EXEC_FORWARDING_EN
        check("fw_m_over_w.const", bus.ALUResultM, 32'd9);
`else
        check("fw_m_over_w.const", bus.ALUResultM, 32'd0);
`endif
        read_srca(5'd5, 32'd0, 5'd6);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd5; bus.ResultW = 32'd4;
        step("fw_w_only");
`ifdef EXEC_FORWARDING_EN
        check("fw_w_only.const", bus.ALUResultM, 32'd4);
`else
        check("fw_w_only.const", bus.ALUResultM, 32'd0);
`endif
        read_srca(5'd0, 32'd9, 5'd0);
        step("fw_x0_producer");
        read_srca(5'd0, 32'd7, 5'd1);
        step("fw_x0_none");
        check("fw_x0_none.const", bus.ALUResultM, 32'd7);

        // 6: store data
        clear_inputs();
        bus.MemWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.RD2E = 32'hAB; bus.RS2E = 5'd7;
        bus.RegWriteW = 1'b1; bus.RDW = 5'd7; bus.ResultW = 32'hCD;
        step("store");
`ifdef EXEC_FORWARDING_EN
        check("store.const", bus.WriteDataM, 32'hCD);
`else
        check("store.const", bus.WriteDataM, 32'hAB);
`endif
        check("store.mw", {31'd0, bus.MemWriteM}, 32'd1);

        // Randomized instructions; small register range to hit forwarding often
        for (int i = 0; i < 300; i++) begin
            bus.RegWriteE   = 1'($urandom_range(0, 1));
            bus.ALUSrcE     = 1'($urandom_range(0, 1));
            bus.MemWriteE   = 1'($urandom_range(0, 1));
            bus.ResultSrcE  = 1'($urandom_range(0, 1));
            bus.BranchE     = 1'($urandom_range(0, 1));
            bus.ALUControlE = 3'($urandom_range(0, 7));
            bus.RD1E        = $urandom;
            bus.RD2E        = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
            bus.ImmExtE     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            bus.PCE         = $urandom;
            bus.PCPlus4E    = bus.PCE + 32'd4;
            bus.RS1E        = 5'($urandom_range(0, 3));
            bus.RS2E        = 5'($urandom_range(0, 3));
            bus.RDE         = 5'($urandom_range(0, 3));
            bus.RegWriteW   = 1'($urandom_range(0, 1));
            bus.RDW         = 5'($urandom_range(0, 3));
            bus.ResultW     = $urandom;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
